// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, bridge FSM states and the
// register-map addresses of the subordinate register bank.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } bridge_state_e;

  localparam logic [7:0]  REG_ADDR_FIRST = 8'h00;
  localparam logic [7:0]  REG_ADDR_LAST  = 8'h1C;
  localparam int unsigned REG_STRIDE     = 4;
  localparam int unsigned REG_COUNT      = 8;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_cmd_bridge_if.sv
// AXI4-Lite bus bundle; master modport is the bridge side.
interface axi4_lite_cmd_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_stat_cnt.sv
// Statistics counter: wraps by default, or holds at all-ones when SATURATE is set.
module axi4_lite_stat_cnt #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !(SATURATE && (count_q == '1)))
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/axi4_lite_cmd_bridge.sv
// Local command/response port to AXI4-Lite manager, one transaction in flight,
// with read/write/error statistics.
module axi4_lite_cmd_bridge
  import axi4_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  axi4_lite_cmd_bridge_if.master  m_axi,
  output logic [CNT_WIDTH-1:0]    rd_count,
  output logic [CNT_WIDTH-1:0]    wr_count,
  output logic [CNT_WIDTH-1:0]    err_count
);
  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("axi4_lite_cmd_bridge: DATA_WIDTH must be 32 or 64");
  end

  bridge_state_e state_q, state_d;
  logic cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [1:0] rsp_resp_q, rsp_resp_d;

  logic aw_fire, w_fire, rd_fire, wr_fire, err_inc;
  assign aw_fire = (state_q == WR_ADDR) && awvalid_q && m_axi.awready;
  assign w_fire  = (state_q == WR_ADDR) && wvalid_q && m_axi.wready;
  assign rd_fire = (state_q == RD_DATA) && rready_q && m_axi.rvalid;
  assign wr_fire = (state_q == WR_RESP) && bready_q && m_axi.bvalid;
  assign err_inc = (rd_fire && resp_is_err(m_axi.rresp)) ||
                   (wr_fire && resp_is_err(m_axi.bresp));

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            awvalid_d = 1'b1;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_ADDR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      RD_ADDR: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rd_fire) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi.rdata;
          rsp_resp_d  = m_axi.rresp;
          state_d     = DONE;
        end
      end
      WR_ADDR: begin
        // AW and W retire independently; a same-cycle completion counts for both
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (wr_fire) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi.bresp;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  axi4_lite_stat_cnt #(.WIDTH(CNT_WIDTH), .SATURATE(1'b0)) u_rd_cnt (
    .aclk(aclk), .aresetn(aresetn), .inc_i(rd_fire), .count_o(rd_count));
  axi4_lite_stat_cnt #(.WIDTH(CNT_WIDTH), .SATURATE(1'b0)) u_wr_cnt (
    .aclk(aclk), .aresetn(aresetn), .inc_i(wr_fire), .count_o(wr_count));
  axi4_lite_stat_cnt #(.WIDTH(CNT_WIDTH), .SATURATE(1'b1)) u_err_cnt (
    .aclk(aclk), .aresetn(aresetn), .inc_i(err_inc), .count_o(err_count));
endmodule

// File: tb/tb_axi4_lite_cmd_bridge.sv
// Scoreboard bench for axi4_lite_cmd_bridge with a behavioural AXI4-Lite register bank.
module tb_axi4_lite_cmd_bridge;
  import axi4_lite_pkg::*;

  localparam int unsigned CW = 3;

  logic aclk = 1'b0;
  logic aresetn;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0] cmd_wstrb;
  logic rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [CW-1:0] rd_count, wr_count, err_count;

  axi4_lite_cmd_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_cmd_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .m_axi(axi),
    .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count));

  always #5 aclk = ~aclk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic wr; logic [31:0] rdata; logic [1:0] resp; } exp_t;
  exp_t sb_q[$];

  // response monitor
  always @(negedge aclk) begin
    if (aresetn && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_write", 64'(rsp_write), 64'(e.wr));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_resp",  64'(rsp_resp),  64'(e.resp));
      end
    end
  end

  // edge recorder for AXI valid/ready ordering
  int cyc = 0;
  int aw_fall, w_fall, b_rise;
  logic p_aw = 1'b0, p_w = 1'b0, p_b = 1'b0;
  initial forever begin @(posedge aclk); cyc++; end
  always @(negedge aclk) begin
    if (p_aw && !axi.awvalid) aw_fall = cyc;
    if (p_w && !axi.wvalid)   w_fall  = cyc;
    if (!p_b && axi.bready)   b_rise  = cyc;
    p_aw = axi.awvalid; p_w = axi.wvalid; p_b = axi.bready;
  end

  // subordinate register bank
  logic [31:0] mem [REG_COUNT];
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0;
  logic aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] aw_cap, w_cap;
  logic [3:0] ws_cap;

  initial begin : rd_sub
    logic [31:0] a;
    logic aborted;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    forever begin
      @(negedge aclk);
      if (aresetn && axi.arvalid) begin
        repeat (ar_delay) @(negedge aclk);
        axi.arready = 1'b1;
        @(posedge aclk); #1;
        axi.arready = 1'b0;
        a = axi.araddr;
        aborted = 1'b0;
        for (int i = 0; i <= r_delay; i++) begin
          @(negedge aclk);
          if (!aresetn) begin aborted = 1'b1; break; end
        end
        if (!aborted) begin
          axi.rvalid = 1'b1;
          if (a <= 32'(REG_ADDR_LAST)) begin
            axi.rdata = mem[a[4:2]]; axi.rresp = RESP_OKAY;
          end else begin
            axi.rdata = {16'hBAD0, a[15:0]}; axi.rresp = RESP_SLVERR;
          end
          for (int i = 0; i < 200 && !axi.rready && aresetn; i++) @(negedge aclk);
          if (aresetn && axi.rready) begin @(posedge aclk); #1; end
          axi.rvalid = 1'b0;
        end
      end
    end
  end

  initial begin : aw_sub
    axi.awready = 1'b0;
    forever begin
      @(negedge aclk);
      if (aresetn && axi.awvalid) begin
        repeat (aw_delay) @(negedge aclk);
        axi.awready = 1'b1;
        @(posedge aclk); #1;
        axi.awready = 1'b0;
        aw_cap = axi.awaddr; aw_got = 1'b1;
      end
    end
  end

  initial begin : w_sub
    axi.wready = 1'b0;
    forever begin
      @(negedge aclk);
      if (aresetn && axi.wvalid) begin
        repeat (w_delay) @(negedge aclk);
        axi.wready = 1'b1;
        @(posedge aclk); #1;
        axi.wready = 1'b0;
        w_cap = axi.wdata; ws_cap = axi.wstrb; w_got = 1'b1;
      end
    end
  end

  initial begin : b_sub
    axi.bvalid = 1'b0; axi.bresp = '0;
    forever begin
      @(negedge aclk);
      if (aw_got && w_got) begin
        aw_got = 1'b0; w_got = 1'b0;
        if (aw_cap <= 32'(REG_ADDR_LAST)) begin
          for (int b = 0; b < 4; b++)
            if (ws_cap[b]) mem[aw_cap[4:2]][8*b +: 8] = w_cap[8*b +: 8];
          axi.bresp = RESP_OKAY;
        end else begin
          axi.bresp = RESP_SLVERR;
        end
        axi.bvalid = 1'b1;
        for (int i = 0; i < 200 && !axi.bready; i++) @(negedge aclk);
        @(posedge aclk); #1;
        axi.bvalid = 1'b0;
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] exp_rd, input logic [1:0] exp_rs);
    int n;
    exp_t e;
    e.wr = wr; e.rdata = exp_rd; e.resp = exp_rs;
    sb_q.push_back(e);
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    n = 0;
    do begin @(negedge aclk); n++; end while (!cmd_ready && n < 200);
    if (!cmd_ready) chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin @(negedge aclk); n++; end
    if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic chk_counts(input string tag, input int rd, input int wr, input int er);
    chk({tag, "_rd_count"},  64'(rd_count),  64'(rd));
    chk({tag, "_wr_count"},  64'(wr_count),  64'(wr));
    chk({tag, "_err_count"}, 64'(err_count), 64'(er));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outputs"}, 64'(|{cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        axi.awaddr, axi.awvalid, axi.wdata, axi.wstrb, axi.wvalid, axi.bready,
        axi.araddr, axi.arvalid, axi.rready}), 64'd0);
    chk_counts(tag, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < int'(REG_COUNT); i++) mem[i] = '0;
    mem[0] = 32'hA5A5_0000;
    mem[1] = 32'hCECE_BBBB;
    mem[4] = 32'h0000_1010;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge aclk);
    #3 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    // read, zero-wait subordinate
    issue(1'b0, 32'h04, '0, '0, 32'hCECE_BBBB, RESP_OKAY);
    drain();
    chk_counts("t1", 1, 0, 0);

    // write, W accepted 3 cycles before AW
    aw_delay = 3; w_delay = 0; aw_fall = -1; w_fall = -1; b_rise = -1;
    issue(1'b1, 32'h08, 32'h1234_5678, 4'hF, 32'h0, RESP_OKAY);
    drain();
    chk("t2_w_before_aw", 64'(aw_fall - w_fall), 64'd3);
    chk("t2_bready_after_both", 64'(b_rise), 64'(aw_fall));
    issue(1'b0, 32'h08, '0, '0, 32'h1234_5678, RESP_OKAY);
    drain();
    chk_counts("t2", 2, 1, 0);

    // simultaneous AW/W handshake, partial strobes
    aw_delay = 0; aw_fall = -1; w_fall = -1; b_rise = -1;
    issue(1'b1, 32'h0C, 32'hA1B2_C3D4, 4'b0101, 32'h0, RESP_OKAY);
    drain();
    chk("t3_same_edge", 64'(aw_fall), 64'(w_fall));
    chk("t3_bready_edge", 64'(b_rise), 64'(aw_fall));
    chk_counts("t3w", 2, 2, 0);
    issue(1'b0, 32'h0C, '0, '0, 32'h00B2_00D4, RESP_OKAY);
    drain();

    // error response
    issue(1'b0, 32'h40, '0, '0, 32'hBAD0_0040, RESP_SLVERR);
    drain();
    chk_counts("t4", 4, 2, 1);

    // response backpressure with a pending command
    @(posedge aclk); #1 rsp_ready = 1'b0;
    issue(1'b0, 32'h08, '0, '0, 32'h1234_5678, RESP_OKAY);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge aclk); n++; end
    chk("t5_rsp_valid_seen", 64'(rsp_valid), 64'd1);
    chk("t5_count_before_accept", 64'(rd_count), 64'd5);
    @(posedge aclk); #1;
    sb_q.push_back('{wr: 1'b0, rdata: 32'h0000_1010, resp: RESP_OKAY});
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t5_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t5_hold_rdata", 64'(rsp_rdata), 64'h1234_5678);
      chk("t5_cmd_ready_low", 64'(cmd_ready), 64'd0);
      chk("t5_no_new_ar", 64'(axi.arvalid), 64'd0);
    end
    @(posedge aclk); #1 rsp_ready = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!cmd_ready && n < 200);
    chk("t5_accept_after_rsp", 64'(sb_q.size()), 64'd1);
    @(posedge aclk); #1 cmd_valid = 1'b0;
    drain();
    chk_counts("t5", 6, 2, 1);

    // reset while in RD_DATA
    r_delay = 10;
    issue(1'b0, 32'h14, '0, '0, 32'h0, RESP_OKAY);
    n = 0;
    while (!axi.rready && n < 200) begin @(negedge aclk); n++; end
    chk("t6_in_rd_data", 64'(axi.rready), 64'd1);
    @(posedge aclk); #3 aresetn = 1'b0;
    sb_q.delete();
    #1;
    chk_all_zero("t6_reset");
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    #1 chk("t6_cmd_ready_pre_edge", 64'(cmd_ready), 64'd0);
    @(posedge aclk); #1;
    chk("t6_cmd_ready_first_clk", 64'(cmd_ready), 64'd1);
    r_delay = 0;
    issue(1'b0, 32'h00, '0, '0, 32'hA5A5_0000, RESP_OKAY);
    drain();
    chk_counts("t6", 1, 0, 0);

    // counter wrap and error saturation
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 32'h44, '0, '0, 32'hBAD0_0044, RESP_SLVERR);
      drain();
    end
    chk_counts("t7", 1, 0, 7);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
